// File: rtl/nx_bit_walker.sv
// Walks an accepted mask from its most significant set bit downward, emitting
// the leading-zero position of each set bit, one per index handshake.
module nx_bit_walker #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INDEX_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   abort_i,
  input  logic [WIDTH-1:0]       mask_i,
  input  logic                   mask_valid_i,
  output logic                   mask_ready_o,
  output logic [INDEX_WIDTH-1:0] index_o,
  output logic                   index_last_o,
  output logic                   index_valid_o,
  input  logic                   index_ready_i,
  output logic                   busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  state_t                 state;
  logic [WIDTH-1:0]       remaining;
  logic [WIDTH-1:0]       top_bit;
  logic [INDEX_WIDTH-1:0] top_idx;
  logic                   one_left;
  logic                   index_hs;
  logic                   mask_hs;

  // Highest set bit of remaining; later (higher) positions override lower ones.
  always_comb begin
    top_bit = '0;
    top_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (remaining[i]) begin
        top_bit = WIDTH'(1) << i;
        top_idx = INDEX_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign one_left = (remaining != '0) && ((remaining & (remaining - WIDTH'(1))) == '0);

  assign index_valid_o = (state == WALK);
  assign busy_o        = (state == WALK);
  assign mask_ready_o  = (state == IDLE) && !abort_i;
  assign index_o       = top_idx;
  assign index_last_o  = (state == WALK) && one_left;

  assign index_hs = index_valid_o && index_ready_i;
  assign mask_hs  = mask_ready_o && mask_valid_i;

  // Abort wins over any handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      remaining <= '0;
    end else if (abort_i) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        WALK: begin
          if (index_hs) begin
            remaining <= remaining & ~top_bit;
            if (one_left) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          // A zero mask is consumed without leaving IDLE.
          if (mask_hs && (mask_i != '0)) begin
            remaining <= mask_i;
            state     <= WALK;
          end
        end
      endcase
    end
  end

endmodule
